riscv_mem_arbiter: RTL and testbench

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

---
 rtl/riscv_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// Arbiter that lets an instruction-fetch port and a load/store port share one
// memory port. At most one transaction is outstanding. Data wins a tie, but
// fetch is guaranteed a grant after STARVE_MAX back-to-back data grants.
module riscv_mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  // load/store port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // shared memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          owner_q, owner_d;      // 1 = data port owns the transaction
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          fetch_win;

  // State, starvation counter and latched command registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= 4'h0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Arbitration, next-state and per-port grant/response outputs.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    i_rvalid     = 1'b0;
    d_rvalid     = 1'b0;
    i_rdata      = 32'h0;
    d_rdata      = 32'h0;
    fetch_win    = i_req && (!d_req || (starve_cnt_q == STARVE_LIM));

    case (state_q)
      IDLE: begin
        // Grants are suppressed while reset is held, since reset is asynchronous
        // and the request inputs may still be active.
        if ((i_req || d_req) && !reset) begin
          state_d = ISSUE;
          if (fetch_win) begin
            i_gnt        = 1'b1;
            owner_d      = 1'b0;
            we_d         = 1'b0;
            be_d         = 4'hF;
            addr_d       = i_addr;
            wdata_d      = 32'h0;
            starve_cnt_d = '0;
          end else begin
            d_gnt   = 1'b1;
            owner_d = 1'b1;
            we_d    = d_we;
            be_d    = d_be;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            // Only a data grant that made fetch wait counts toward starvation.
            if (!i_req) begin
              starve_cnt_d = '0;
            end else if (starve_cnt_q != STARVE_LIM) begin
              starve_cnt_d = starve_cnt_q + CW'(1);
            end
          end
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          state_d = RESP;
        end
      end
      RESP: begin
        // Response is forwarded combinationally to whichever port owns it.
        if (mem_rvalid) begin
          state_d = IDLE;
          if (owner_q) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end else begin
            i_rvalid = 1'b1;
            i_rdata  = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: a directed vector table, hand
// sequences for starvation and reset-in-RESP, and a randomized phase checked
// against a transaction-level model of the arbitration rules.
module tb_riscv_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;
  int s_model = 0;   // model of consecutive data grants while fetch waited

  riscv_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ireq;
    bit          dreq;
    logic [31:0] iaddr;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] rdata;
    int          gw;
    int          rw;
    bit          stale;
    bit          exp_data;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge and return memory inputs to idle.
  task automatic step();
    @(posedge clk);
    #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Spec-level arbitration rule: returns 1 when data should win.
  function automatic bit model_pick(input bit ip, input bit dp);
    return !(ip && (!dp || s_model == STARVE_MAX));
  endfunction

  task automatic model_update(input bit data_won, input bit ip);
    if (!data_won || !ip) s_model = 0;
    else if (s_model < STARVE_MAX) s_model = s_model + 1;
  endtask

  // Runs one transaction whose requests are already driven for the current
  // (IDLE) cycle: grant, gw stalled ISSUE cycles, rw waiting RESP cycles.
  task automatic do_txn(input bit exp_data, input logic exp_we, input logic [3:0] exp_be,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                        input logic [31:0] rdata, input int gw, input int rw, input bit stale);
    @(negedge clk);
    chk("i_gnt", i_gnt, !exp_data);
    chk("d_gnt", d_gnt, exp_data);
    chk("busy_idle", busy, 0);
    chk("mem_req_idle", mem_req, 0);
    for (int k = 0; k <= gw; k++) begin
      step();
      if (k == 0) begin
        if (exp_data) d_req = 1'b0;
        else          i_req = 1'b0;
      end
      mem_gnt    = (k == gw);
      mem_rvalid = stale && (k == 0);
      @(negedge clk);
      chk("mem_req_issue", mem_req, 1);
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_we", mem_we, exp_we);
      chk("mem_be", mem_be, exp_be);
      chk("mem_wdata", mem_wdata, exp_wdata);
      chk("busy_issue", busy, 1);
      chk("gnt_busy", {i_gnt, d_gnt}, 0);
      chk("rvalid_issue", {i_rvalid, d_rvalid}, 0);
    end
    for (int k = 0; k <= rw; k++) begin
      step();
      mem_rvalid = (k == rw);
      if (k == rw) mem_rdata = rdata;
      @(negedge clk);
      chk("mem_req_resp", mem_req, 0);
      chk("busy_resp", busy, 1);
      chk("gnt_resp", {i_gnt, d_gnt}, 0);
      chk("i_rvalid", i_rvalid, (k == rw) && !exp_data);
      chk("d_rvalid", d_rvalid, (k == rw) && exp_data);
      if (k == rw) begin
        if (exp_data) chk("d_rdata", d_rdata, rdata);
        else          chk("i_rdata", i_rdata, rdata);
      end
    end
    txn_no++;
    $display("txn %0d owner=%s we=%0d be=%h addr=%h wdata=%h rdata=%h gw=%0d rw=%0d",
             txn_no, exp_data ? "data" : "fetch", exp_we, exp_be, exp_addr, exp_wdata,
             rdata, gw, rw);
  endtask

  // Both ports held: exactly STARVE_MAX data grants, one fetch, then data again.
  task automatic starve_seq();
    for (int r = 0; r < STARVE_MAX + 2; r++) begin
      step();
      i_req   = 1'b1;
      i_addr  = 32'h80;
      d_req   = 1'b1;
      d_we    = r[0];
      d_be    = 4'hF;
      d_addr  = 32'h1000 + 32'(r * 4);
      d_wdata = 32'h5000 + 32'(r);
      if (r == STARVE_MAX)
        do_txn(1'b0, 1'b0, 4'hF, 32'h80, 32'h0, 32'h1111_0000 + 32'(r), 0, 0, 1'b0);
      else
        do_txn(1'b1, r[0], 4'hF, 32'h1000 + 32'(r * 4), 32'h5000 + 32'(r),
               32'h2222_0000 + 32'(r), 0, 0, 1'b0);
    end
    step();
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1, 0, 32'h4, 0, 4'h0, 32'h0, 32'h0, 32'h00600113, 0, 0, 0,
                0, 0, 4'hF, 32'h4, 32'h0};
    vecs[1] = '{1, 1, 32'h8, 1, 4'hF, 32'h100, 32'hDEADBEEF, 32'h12345678, 0, 0, 0,
                1, 1, 4'hF, 32'h100, 32'hDEADBEEF};
    vecs[2] = '{1, 0, 32'h8, 0, 4'h0, 32'h0, 32'h0, 32'h00000013, 0, 1, 0,
                0, 0, 4'hF, 32'h8, 32'h0};
    vecs[3] = '{0, 1, 32'h0, 0, 4'h3, 32'h200, 32'hFFFFFFFF, 32'hCAFEF00D, 2, 1, 0,
                1, 0, 4'h3, 32'h200, 32'hFFFFFFFF};
    vecs[4] = '{1, 0, 32'h40, 0, 4'h0, 32'h0, 32'h0, 32'hA5A5A5A5, 3, 2, 1,
                0, 0, 4'hF, 32'h40, 32'h0};
    vecs[5] = '{1, 1, 32'h44, 1, 4'h1, 32'h300, 32'h000000AB, 32'h0BADF00D, 1, 0, 0,
                1, 1, 4'h1, 32'h300, 32'h000000AB};

    // Reset with requests and a stray response active: everything must stay low.
    reset = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 32'hFFFF_FFF0;
    d_we = 1'b1; d_be = 4'hF; d_addr = 32'hFFFF_FFF4; d_wdata = 32'hFFFF_FFFF;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rst_gnt", {i_gnt, d_gnt}, 0);
    chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
    chk("rst_rdata_i", i_rdata, 0);
    chk("rst_rdata_d", d_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    step();
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("idle_no_gnt", {i_gnt, d_gnt}, 0);
    chk("idle_busy", busy, 0);

    // Directed vector table.
    for (int v = 0; v < 6; v++) begin
      step();
      i_req = vecs[v].ireq; i_addr = vecs[v].iaddr;
      d_req = vecs[v].dreq; d_we = vecs[v].dwe; d_be = vecs[v].dbe;
      d_addr = vecs[v].daddr; d_wdata = vecs[v].dwdata;
      do_txn(vecs[v].exp_data, vecs[v].exp_we, vecs[v].exp_be, vecs[v].exp_addr,
             vecs[v].exp_wdata, vecs[v].rdata, vecs[v].gw, vecs[v].rw, vecs[v].stale);
    end
    step();
    i_req = 1'b0; d_req = 1'b0;

    // Starvation limit.
    do_reset();
    starve_seq();

    // Reset while waiting in RESP, after building up some starvation count.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      step();
      i_req = 1'b1; i_addr = 32'h90; d_req = 1'b1; d_we = 1'b0; d_be = 4'hF;
      d_addr = 32'h400 + 32'(r * 4); d_wdata = 32'h0;
      do_txn(1'b1, 1'b0, 4'hF, 32'h400 + 32'(r * 4), 32'h0, 32'h3333_0000 + 32'(r), 0, 0, 1'b0);
    end
    step();
    d_req = 1'b1; d_addr = 32'h500; d_we = 1'b1; d_wdata = 32'h77;
    @(negedge clk);
    chk("rr_d_gnt", d_gnt, 1);
    step();
    d_req = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    chk("rr_mem_req", mem_req, 1);
    step();
    @(negedge clk);
    chk("rr_in_resp", {busy, mem_req}, 2'b10);
    #2;
    reset = 1'b1;
    #1;
    chk("rr_mem_req_drop", mem_req, 0);
    chk("rr_busy_drop", busy, 0);
    chk("rr_gnt_in_rst", {i_gnt, d_gnt}, 0);
    chk("rr_mem_fields", {mem_we, mem_be, mem_addr, mem_wdata} == '0, 1);
    step();
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("rr_stale_rvalid", {i_rvalid, d_rvalid}, 0);
    chk("rr_idle", busy, 0);
    chk("rr_no_gnt", {i_gnt, d_gnt}, 0);
    starve_seq();

    // Randomized transactions against the transaction-level model.
    do_reset();
    s_model = 0;
    begin
      bit ip = 0, dp = 0;
      for (int n = 0; n < 60; n++) begin
        bit win;
        step();
        if (!ip && ($urandom_range(0, 1) == 1)) begin
          ip = 1; i_addr = $urandom;
        end
        if (!dp && ($urandom_range(0, 1) == 1)) begin
          dp = 1; d_we = $urandom_range(0, 1); d_be = 4'($urandom);
          d_addr = $urandom; d_wdata = $urandom;
        end
        i_req = ip;
        d_req = dp;
        if (!ip && !dp) begin
          @(negedge clk);
          chk("rand_idle_gnt", {i_gnt, d_gnt}, 0);
          chk("rand_idle_busy", busy, 0);
        end else begin
          win = model_pick(ip, dp);
          model_update(win, ip);
          if (win)
            do_txn(1'b1, d_we, d_be, d_addr, d_wdata, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
          else
            do_txn(1'b0, 1'b0, 4'hF, i_addr, 32'h0, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
          if (win) dp = 0;
          else     ip = 0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
